// File: rtl/i2c_scl_gen.sv
// SCL phase generator: splits each SCL period into four equal quarter-phases with a
// one-cycle strobe per phase, clock stretching in P2 and stop only on a period boundary.
module i2c_scl_gen #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 125,
  parameter bit          STRETCH_EN  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_load_i,
  input  logic                 scl_i,
  output logic                 scl_o,
  output logic                 tick_o,
  output logic [1:0]           phase_o,
  output logic                 stretch_o,
  output logic                 busy_o
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e               r_state, w_state_d;
  logic [DIV_WIDTH-1:0] r_cnt, w_cnt_d;
  logic [DIV_WIDTH-1:0] r_div_act, w_div_act_d;
  logic [DIV_WIDTH-1:0] r_div_shd, w_div_shd_d;
  logic [1:0]           r_phase, w_phase_d;
  logic                 r_scl, w_scl_d;
  logic                 r_tick, w_tick_d;
  logic                 r_stretch, w_stretch_d;
  logic                 r_busy, w_busy_d;

  logic [DIV_WIDTH-1:0] w_div_clamped;
  logic [DIV_WIDTH-1:0] w_p0_div;
  logic [1:0]           w_phase_inc;

  assign w_div_clamped = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_i;
  // A load coinciding with P0 entry must take effect for that same period.
  assign w_p0_div      = div_load_i ? w_div_clamped : r_div_shd;
  assign w_phase_inc   = r_phase + 2'd1;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_div_act_d = r_div_act;
    w_div_shd_d = div_load_i ? w_div_clamped : r_div_shd;
    w_phase_d   = r_phase;
    w_scl_d     = r_scl;
    w_tick_d    = 1'b0;
    w_stretch_d = 1'b0;
    w_busy_d    = r_busy;

    unique case (r_state)
      StIdle: begin
        w_cnt_d   = '0;
        w_phase_d = 2'd0;
        w_scl_d   = 1'b1;
        w_busy_d  = 1'b0;
        if (en_i) begin
          w_state_d   = StRun;
          w_tick_d    = 1'b1;
          w_scl_d     = 1'b0;
          w_busy_d    = 1'b1;
          w_div_act_d = w_p0_div;
        end
      end
      StRun: begin
        if (STRETCH_EN && (r_phase == 2'd2) && !scl_i) begin
          w_stretch_d = 1'b1;
        end else if (r_cnt == r_div_act - DIV_WIDTH'(1)) begin
          w_cnt_d = '0;
          if (r_phase == 2'd3) begin
            w_phase_d = 2'd0;
            if (!en_i) begin
              w_state_d = StIdle;
              w_scl_d   = 1'b1;
              w_busy_d  = 1'b0;
            end else begin
              w_tick_d    = 1'b1;
              w_scl_d     = 1'b0;
              w_div_act_d = w_p0_div;
            end
          end else begin
            w_phase_d = w_phase_inc;
            w_tick_d  = 1'b1;
            w_scl_d   = w_phase_inc[1];
          end
        end else begin
          w_cnt_d = r_cnt + DIV_WIDTH'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_div_act <= DIV_WIDTH'(DEFAULT_DIV);
      r_div_shd <= DIV_WIDTH'(DEFAULT_DIV);
      r_phase   <= 2'd0;
      r_scl     <= 1'b1;
      r_tick    <= 1'b0;
      r_stretch <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_div_act <= w_div_act_d;
      r_div_shd <= w_div_shd_d;
      r_phase   <= w_phase_d;
      r_scl     <= w_scl_d;
      r_tick    <= w_tick_d;
      r_stretch <= w_stretch_d;
      r_busy    <= w_busy_d;
    end
  end

  assign scl_o     = r_scl;
  assign tick_o    = r_tick;
  assign phase_o   = r_phase;
  assign stretch_o = r_stretch;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Scoreboard bench for i2c_scl_gen: each expected tick (phase, SCL level, length of the
// preceding phase) is queued by the stimulus and checked by an independent monitor.
module tb_i2c_scl_gen;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        en_i;
  logic [15:0] div_i;
  logic        div_load_i;
  logic        scl_i;
  logic        scl_o;
  logic        tick_o;
  logic [1:0]  phase_o;
  logic        stretch_o;
  logic        busy_o;

  i2c_scl_gen #(
    .DIV_WIDTH  (16),
    .DEFAULT_DIV(125),
    .STRETCH_EN (1'b1)
  ) dut (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .en_i      (en_i),
    .div_i     (div_i),
    .div_load_i(div_load_i),
    .scl_i     (scl_i),
    .scl_o     (scl_o),
    .tick_o    (tick_o),
    .phase_o   (phase_o),
    .stretch_o (stretch_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int phase;
    int scl;
    int len;  // cycles since previous tick; 0 = first tick of a run, not timed
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   last_tick = 0;
  int   tick_count = 0;
  int   exp_ticks = 0;
  int   stretch_cnt = 0;
  int   prev_len = 0;
  int   base = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    exp_t e;
    cyc++;
    if (stretch_o) stretch_cnt++;
    if (tick_o) begin
      tick_count++;
      if (q.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        e = q.pop_front();
        chk("tick_phase", int'(phase_o), e.phase);
        chk("tick_scl", int'(scl_o), e.scl);
        if (e.len != 0) chk("phase_len", cyc - last_tick, e.len);
      end
      last_tick = cyc;
    end
  end

  task automatic push_tick(input int ph, input int s, input int len);
    exp_t e;
    e.phase = ph;
    e.scl   = s;
    e.len   = len;
    q.push_back(e);
    exp_ticks++;
  endtask

  task automatic push_period(input int d, input int p2x);
    push_tick(0, 0, prev_len);
    push_tick(1, 0, d);
    push_tick(2, 1, d);
    push_tick(3, 1, d + p2x);
    prev_len = d;
  endtask

  task automatic load_div(input int v);
    div_i      = 16'(v);
    div_load_i = 1'b1;
    @(posedge clk_i);
    #1;
    div_load_i = 1'b0;
  endtask

  task automatic wait_ticks(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (tick_count >= target) return;
      @(negedge clk_i);
      #1;
    end
    chk("tick_timeout", tick_count, target);
  endtask

  task automatic start_run();
    prev_len = 0;
    base     = tick_count;
    en_i     = 1'b1;
  endtask

  // Waits for the graceful stop and checks the final P3 length and idle state.
  task automatic finish_run(input int last_d);
    int t0;
    t0 = 0;
    while (busy_o && t0 < 3000) begin
      @(negedge clk_i);
      #1;
      t0++;
    end
    chk("stop_busy", int'(busy_o), 0);
    chk("stop_p3_len", cyc - last_tick, last_d);
    chk("stop_scl", int'(scl_o), 1);
    repeat (20) @(posedge clk_i);
    #1;
    chk("no_extra_ticks", tick_count, exp_ticks);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    arstn_i    = 1'b0;
    en_i       = 1'b0;
    div_i      = '0;
    div_load_i = 1'b0;
    scl_i      = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_scl", int'(scl_o), 1);
    chk("rst_tick", int'(tick_o), 0);
    chk("rst_phase", int'(phase_o), 0);
    chk("rst_stretch", int'(stretch_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    arstn_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Basic run at div=4: 4-cycle phases, stop requested during P1.
    load_div(4);
    push_period(4, 0);
    start_run();
    wait_ticks(base + 2);
    en_i = 1'b0;
    finish_run(4);

    // Stretch: scl_i held low for 10 cycles from P2 start.
    stretch_cnt = 0;
    push_period(4, 10);
    start_run();
    wait_ticks(base + 2);
    en_i = 1'b0;
    wait_ticks(base + 3);
    scl_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    scl_i = 1'b1;
    finish_run(4);
    chk("stretch_cycles", stretch_cnt, 10);

    // Reload during P1: current period stays at 4, next period uses 6.
    push_period(4, 0);
    push_period(6, 0);
    start_run();
    wait_ticks(base + 2);
    load_div(6);
    wait_ticks(base + 6);
    en_i = 1'b0;
    finish_run(6);

    // Clamping: 1 and 0 both give div=2.
    load_div(1);
    push_period(2, 0);
    start_run();
    wait_ticks(base + 2);
    en_i = 1'b0;
    finish_run(2);
    load_div(0);
    push_period(2, 0);
    start_run();
    wait_ticks(base + 2);
    en_i = 1'b0;
    finish_run(2);

    // Async reset while the P2 tick is high, then restart at the default divider.
    load_div(4);
    prev_len = 0;
    push_tick(0, 0, 0);
    push_tick(1, 0, 4);
    push_tick(2, 1, 4);
    start_run();
    wait_ticks(base + 3);
    arstn_i = 1'b0;
    en_i    = 1'b0;
    #1;
    chk("arst_tick", int'(tick_o), 0);
    chk("arst_phase", int'(phase_o), 0);
    chk("arst_scl", int'(scl_o), 1);
    chk("arst_busy", int'(busy_o), 0);
    repeat (2) @(posedge clk_i);
    #1;
    arstn_i = 1'b1;
    chk("arst_queue", q.size(), 0);
    @(posedge clk_i);
    #1;
    push_period(125, 0);
    start_run();
    wait_ticks(base + 2);
    en_i = 1'b0;
    finish_run(125);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
